// File: rtl/isr_sequencer_if.sv
// Handler/core <-> isr_sequencer signal bundle.
// master = interrupt handler plus core side, slave = the sequencer.
interface isr_sequencer_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned FLAG_W = 2
);
    logic              irq_req;
    logic [XLEN-1:0]   irq_vector;
    logic              irq_enable;
    logic              instr_boundary;
    logic [XLEN-1:0]   pc_next;
    logic [FLAG_W-1:0] flags_in;
    logic              reti;
    logic              pc_redirect;
    logic [XLEN-1:0]   pc_target;
    logic              flags_restore;
    logic [FLAG_W-1:0] flags_out;
    logic              in_isr;
    logic              irq_ack;
    logic              irq_dropped;

    modport master (
        output irq_req, irq_vector, irq_enable, instr_boundary, pc_next, flags_in, reti,
        input  pc_redirect, pc_target, flags_restore, flags_out, in_isr, irq_ack, irq_dropped
    );

    modport slave (
        input  irq_req, irq_vector, irq_enable, instr_boundary, pc_next, flags_in, reti,
        output pc_redirect, pc_target, flags_restore, flags_out, in_isr, irq_ack, irq_dropped
    );
endinterface

// File: rtl/isr_sequencer.sv
// Interrupt entry/return sequencer: pends one request, redirects fetch at a boundary, restores on reti.
// Optional nesting (LIFO of saved PC/flags) is enabled with `define ISR_NEST_EN.
module isr_sequencer #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FLAG_W     = 2,
    parameter int unsigned NEST_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    isr_sequencer_if.slave bus
);
    typedef enum logic {IDLE, IN_ISR} state_e;

    state_e            state_q, state_d;
    logic              pend_v_q, pend_v_d;
    logic [XLEN-1:0]   pend_vec_q, pend_vec_d;
    logic              pc_redirect_q, pc_redirect_d;
    logic [XLEN-1:0]   pc_target_q, pc_target_d;
    logic              flags_restore_q, flags_restore_d;
    logic [FLAG_W-1:0] flags_out_q, flags_out_d;
    logic              in_isr_q, in_isr_d;
    logic              irq_ack_q, irq_ack_d;
    logic              irq_dropped_q, irq_dropped_d;
    logic              can_take_c, take_c, ret_c;
    logic [XLEN-1:0]   top_pc_c;
    logic [FLAG_W-1:0] top_flags_c;

`ifdef ISR_NEST_EN
    localparam int unsigned DW = $clog2(NEST_DEPTH + 1);
    localparam int unsigned IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(NEST_DEPTH);

    logic [XLEN-1:0]   epc_q    [NEST_DEPTH];
    logic [FLAG_W-1:0] eflags_q [NEST_DEPTH];
    logic [DW-1:0]     depth_q, depth_d;
    logic [IW-1:0]     push_idx_c, top_idx_c;

    assign push_idx_c  = IW'(depth_q);
    assign top_idx_c   = IW'(depth_q - DW'(1));
    assign top_pc_c    = epc_q[top_idx_c];
    assign top_flags_c = eflags_q[top_idx_c];

    // Save stack: push on take, pop on return (never both in one cycle).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q <= '0;
            for (int i = 0; i < int'(NEST_DEPTH); i++) begin
                epc_q[i]    <= '0;
                eflags_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            if (take_c) begin
                epc_q[push_idx_c]    <= bus.pc_next;
                eflags_q[push_idx_c] <= bus.flags_in;
            end
        end
    end

    always_comb begin
        depth_d = depth_q;
        if (take_c)     depth_d = depth_q + DW'(1);
        else if (ret_c) depth_d = depth_q - DW'(1);
    end
`else
    logic [XLEN-1:0]   epc_q;
    logic [FLAG_W-1:0] eflags_q;

    assign top_pc_c    = epc_q;
    assign top_flags_c = eflags_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc_q    <= '0;
            eflags_q <= '0;
        end else if (take_c) begin
            epc_q    <= bus.pc_next;
            eflags_q <= bus.flags_in;
        end
    end
`endif

    assign can_take_c = pend_v_q & bus.irq_enable & bus.instr_boundary & ~bus.reti;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pend_v_q        <= 1'b0;
            pend_vec_q      <= '0;
            pc_redirect_q   <= 1'b0;
            pc_target_q     <= '0;
            flags_restore_q <= 1'b0;
            flags_out_q     <= '0;
            in_isr_q        <= 1'b0;
            irq_ack_q       <= 1'b0;
            irq_dropped_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_v_q        <= pend_v_d;
            pend_vec_q      <= pend_vec_d;
            pc_redirect_q   <= pc_redirect_d;
            pc_target_q     <= pc_target_d;
            flags_restore_q <= flags_restore_d;
            flags_out_q     <= flags_out_d;
            in_isr_q        <= in_isr_d;
            irq_ack_q       <= irq_ack_d;
            irq_dropped_q   <= irq_dropped_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pend_v_d        = pend_v_q;
        pend_vec_d      = pend_vec_q;
        pc_redirect_d   = 1'b0;
        pc_target_d     = pc_target_q;
        flags_restore_d = 1'b0;
        flags_out_d     = flags_out_q;
        irq_ack_d       = 1'b0;
        irq_dropped_d   = 1'b0;
        take_c          = 1'b0;
        ret_c           = 1'b0;

        unique case (state_q)
            IDLE: take_c = can_take_c;
            IN_ISR: begin
                ret_c = bus.reti & bus.instr_boundary;
`ifdef ISR_NEST_EN
                take_c = can_take_c & (depth_q < DEPTH_MAX);
                if (ret_c && depth_q == DW'(1)) state_d = IDLE;
`else
                if (ret_c) state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (take_c) begin
            state_d       = IN_ISR;
            pend_v_d      = 1'b0;
            pc_redirect_d = 1'b1;
            pc_target_d   = pend_vec_q;
        end
        if (ret_c) begin
            pc_redirect_d   = 1'b1;
            pc_target_d     = top_pc_c;
            flags_restore_d = 1'b1;
            flags_out_d     = top_flags_c;
            irq_ack_d       = 1'b1;
        end

        // A slot being consumed this edge may accept the new request.
        if (bus.irq_req) begin
            if (!pend_v_q || take_c) begin
                pend_v_d   = 1'b1;
                pend_vec_d = bus.irq_vector;
            end else begin
                irq_dropped_d = 1'b1;
            end
        end

        in_isr_d = (state_d == IN_ISR);
    end

    assign bus.pc_redirect   = pc_redirect_q;
    assign bus.pc_target     = pc_target_q;
    assign bus.flags_restore = flags_restore_q;
    assign bus.flags_out     = flags_out_q;
    assign bus.in_isr        = in_isr_q;
    assign bus.irq_ack       = irq_ack_q;
    assign bus.irq_dropped   = irq_dropped_q;
endmodule
